// File: rtl/sw_rs_pkg.sv
// Shared defaults, packed dispatch-slot offsets and dispatch-count encodings
// for the store-side reservation station.
package sw_rs_pkg;

  localparam int unsigned ENT_SEL_DEF = 2;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TAG_W_DEF   = 6;
  localparam int unsigned OPC_W_DEF   = 8;

  localparam int unsigned SLOT0 = 0;
  localparam int unsigned SLOT1 = 1;

  typedef enum logic [1:0] {
    REQ_NONE    = 2'd0,
    REQ_ONE     = 2'd1,
    REQ_TWO     = 2'd2,
    REQ_ILLEGAL = 2'd3
  } req_num_e;

endpackage

// File: rtl/sw_rs_entry.sv
// One reservation-station entry: busy/ready state, payload storage and
// result-bus tag compare (bypass on write, wakeup while busy). Macro: SW_RS_DUAL_CDB_EN.
module sw_rs_entry
  import sw_rs_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int OPC_W  = OPC_W_DEF
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              kill_i,
  input  logic              we_i,
  input  logic              clr_i,
  input  logic [OPC_W-1:0]  wr_opc_i,
  input  logic [DATA_W-1:0] wr_src1_i,
  input  logic [DATA_W-1:0] wr_src2_i,
  input  logic              wr_rdy1_i,
  input  logic              wr_rdy2_i,
  input  logic [TAG_W-1:0]  wr_dst_tag_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_data_i,
`ifdef SW_RS_DUAL_CDB_EN
  input  logic              cdb1_valid_i,
  input  logic [TAG_W-1:0]  cdb1_tag_i,
  input  logic [DATA_W-1:0] cdb1_data_i,
`endif
  output logic              busy_o,
  output logic              busy_next_o,
  output logic              ready_o,
  output logic [OPC_W-1:0]  opc_o,
  output logic [DATA_W-1:0] src1_o,
  output logic [DATA_W-1:0] src2_o,
  output logic [TAG_W-1:0]  dst_tag_o
);

  logic              busy_q, busy_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [DATA_W-1:0] src1_q, src1_d, src2_q, src2_d;
  logic [OPC_W-1:0]  opc_q, opc_d;
  logic [TAG_W-1:0]  dst_q, dst_d;
  logic [DATA_W-1:0] s1_in, s2_in;
  logic              r1_in, r2_in, live;

  // Incoming dispatch data and stored operands share one capture path.
  assign s1_in = we_i ? wr_src1_i : src1_q;
  assign s2_in = we_i ? wr_src2_i : src2_q;
  assign r1_in = we_i ? wr_rdy1_i : rdy1_q;
  assign r2_in = we_i ? wr_rdy2_i : rdy2_q;
  assign live  = we_i | busy_q;

  always_comb begin
    src1_d = s1_in;
    src2_d = s2_in;
    rdy1_d = r1_in;
    rdy2_d = r2_in;
    opc_d  = we_i ? wr_opc_i : opc_q;
    dst_d  = we_i ? wr_dst_tag_i : dst_q;
    if (live && !r1_in) begin
`ifdef SW_RS_DUAL_CDB_EN
      if (cdb1_valid_i && s1_in[TAG_W-1:0] == cdb1_tag_i) begin
        src1_d = cdb1_data_i;
        rdy1_d = 1'b1;
      end
`endif
      if (cdb_valid_i && s1_in[TAG_W-1:0] == cdb_tag_i) begin
        src1_d = cdb_data_i;
        rdy1_d = 1'b1;
      end
    end
    if (live && !r2_in) begin
`ifdef SW_RS_DUAL_CDB_EN
      if (cdb1_valid_i && s2_in[TAG_W-1:0] == cdb1_tag_i) begin
        src2_d = cdb1_data_i;
        rdy2_d = 1'b1;
      end
`endif
      if (cdb_valid_i && s2_in[TAG_W-1:0] == cdb_tag_i) begin
        src2_d = cdb_data_i;
        rdy2_d = 1'b1;
      end
    end
    if (kill_i)      busy_d = 1'b0;
    else if (we_i)   busy_d = 1'b1;
    else if (clr_i)  busy_d = 1'b0;
    else             busy_d = busy_q;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      busy_q <= 1'b0;
      rdy1_q <= 1'b0;
      rdy2_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      rdy1_q <= rdy1_d;
      rdy2_q <= rdy2_d;
    end
  end

  always_ff @(posedge clk_i) begin
    src1_q <= src1_d;
    src2_q <= src2_d;
    opc_q  <= opc_d;
    dst_q  <= dst_d;
  end

  assign busy_o      = busy_q;
  assign busy_next_o = busy_d;
  assign ready_o     = busy_q & rdy1_q & rdy2_q;
  assign opc_o       = opc_q;
  assign src1_o      = src1_q;
  assign src2_o      = src2_q;
  assign dst_tag_o   = dst_q;

endmodule

// File: rtl/sw_rs_entry_array.sv
// Store-side reservation station storage: dispatch writes, wakeup, busy/ready
// export and registered issue stage. Macro: SW_RS_DUAL_CDB_EN (second result bus).
module sw_rs_entry_array
  import sw_rs_pkg::*;
#(
  parameter int ENT_SEL = ENT_SEL_DEF,
  parameter int ENT_NUM = 2 ** ENT_SEL_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int OPC_W   = OPC_W_DEF
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                dp_stall_i,
  input  logic                dp_kill_i,
  input  logic [1:0]          req_num_i,
  input  logic [ENT_SEL-1:0]  alloc_ptr_i,
  input  logic                allocatable_i,
  input  logic [2*OPC_W-1:0]  dp_opc_i,
  input  logic [2*DATA_W-1:0] dp_src1_i,
  input  logic [2*DATA_W-1:0] dp_src2_i,
  input  logic [1:0]          dp_rdy1_i,
  input  logic [1:0]          dp_rdy2_i,
  input  logic [2*TAG_W-1:0]  dp_dst_tag_i,
  input  logic                cdb_valid_i,
  input  logic [TAG_W-1:0]    cdb_tag_i,
  input  logic [DATA_W-1:0]   cdb_data_i,
`ifdef SW_RS_DUAL_CDB_EN
  input  logic                cdb1_valid_i,
  input  logic [TAG_W-1:0]    cdb1_tag_i,
  input  logic [DATA_W-1:0]   cdb1_data_i,
`endif
  input  logic [ENT_SEL-1:0]  issue_ptr_i,
  input  logic                issue_valid_i,
  input  logic                iss_ready_i,
  output logic [ENT_NUM-1:0]  busy_vector_o,
  output logic [ENT_NUM-1:0]  busy_vector_next_o,
  output logic [ENT_NUM-1:0]  ready_vector_o,
  output logic                issue_fire_o,
  output logic                iss_valid_o,
  output logic [OPC_W-1:0]    iss_opc_o,
  output logic [DATA_W-1:0]   iss_src1_o,
  output logic [DATA_W-1:0]   iss_src2_o,
  output logic [TAG_W-1:0]    iss_dst_tag_o
);

  req_num_e           req;
  logic               we;
  logic [ENT_SEL-1:0] alloc_ptr1;
  logic [ENT_NUM-1:0] wr0, wr1, clr;

  logic [OPC_W-1:0]   e_opc  [ENT_NUM];
  logic [DATA_W-1:0]  e_src1 [ENT_NUM];
  logic [DATA_W-1:0]  e_src2 [ENT_NUM];
  logic [TAG_W-1:0]   e_dst  [ENT_NUM];

  logic               iss_valid_q;
  logic [OPC_W-1:0]   iss_opc_q;
  logic [DATA_W-1:0]  iss_src1_q, iss_src2_q;
  logic [TAG_W-1:0]   iss_dst_q;

  assign req        = req_num_e'(req_num_i);
  assign we         = ~dp_stall_i & ~dp_kill_i & allocatable_i;
  assign alloc_ptr1 = alloc_ptr_i + 1'b1;

  always_comb begin
    wr0 = '0;
    wr1 = '0;
    clr = '0;
    if (we && (req == REQ_ONE || req == REQ_TWO)) wr0[alloc_ptr_i] = 1'b1;
    if (we && req == REQ_TWO)                     wr1[alloc_ptr1]  = 1'b1;
    if (issue_fire_o)                             clr[issue_ptr_i] = 1'b1;
  end

  assign issue_fire_o = issue_valid_i & busy_vector_o[issue_ptr_i]
                      & (~iss_valid_q | iss_ready_i) & ~dp_kill_i;

  for (genvar e = 0; e < ENT_NUM; e++) begin : g_ent
    sw_rs_entry #(
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W),
      .OPC_W  (OPC_W)
    ) u_ent (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .kill_i       (dp_kill_i),
      .we_i         (wr0[e] | wr1[e]),
      .clr_i        (clr[e]),
      .wr_opc_i     (wr1[e] ? dp_opc_i[SLOT1*OPC_W +: OPC_W]      : dp_opc_i[SLOT0*OPC_W +: OPC_W]),
      .wr_src1_i    (wr1[e] ? dp_src1_i[SLOT1*DATA_W +: DATA_W]   : dp_src1_i[SLOT0*DATA_W +: DATA_W]),
      .wr_src2_i    (wr1[e] ? dp_src2_i[SLOT1*DATA_W +: DATA_W]   : dp_src2_i[SLOT0*DATA_W +: DATA_W]),
      .wr_rdy1_i    (wr1[e] ? dp_rdy1_i[SLOT1] : dp_rdy1_i[SLOT0]),
      .wr_rdy2_i    (wr1[e] ? dp_rdy2_i[SLOT1] : dp_rdy2_i[SLOT0]),
      .wr_dst_tag_i (wr1[e] ? dp_dst_tag_i[SLOT1*TAG_W +: TAG_W]  : dp_dst_tag_i[SLOT0*TAG_W +: TAG_W]),
      .cdb_valid_i  (cdb_valid_i),
      .cdb_tag_i    (cdb_tag_i),
      .cdb_data_i   (cdb_data_i),
`ifdef SW_RS_DUAL_CDB_EN
      .cdb1_valid_i (cdb1_valid_i),
      .cdb1_tag_i   (cdb1_tag_i),
      .cdb1_data_i  (cdb1_data_i),
`endif
      .busy_o       (busy_vector_o[e]),
      .busy_next_o  (busy_vector_next_o[e]),
      .ready_o      (ready_vector_o[e]),
      .opc_o        (e_opc[e]),
      .src1_o       (e_src1[e]),
      .src2_o       (e_src2[e]),
      .dst_tag_o    (e_dst[e])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      iss_valid_q <= 1'b0;
      iss_opc_q   <= '0;
      iss_src1_q  <= '0;
      iss_src2_q  <= '0;
      iss_dst_q   <= '0;
    end else if (dp_kill_i) begin
      iss_valid_q <= 1'b0;
    end else if (issue_fire_o) begin
      iss_valid_q <= 1'b1;
      iss_opc_q   <= e_opc[issue_ptr_i];
      iss_src1_q  <= e_src1[issue_ptr_i];
      iss_src2_q  <= e_src2[issue_ptr_i];
      iss_dst_q   <= e_dst[issue_ptr_i];
    end else if (iss_ready_i) begin
      iss_valid_q <= 1'b0;
    end
  end

  assign iss_valid_o   = iss_valid_q;
  assign iss_opc_o     = iss_opc_q;
  assign iss_src1_o    = iss_src1_q;
  assign iss_src2_o    = iss_src2_q;
  assign iss_dst_tag_o = iss_dst_q;

endmodule

// File: tb/tb_sw_rs_entry_array.sv
// Directed bench for sw_rs_entry_array: issued ops are queued as expectations
// and a monitor checks each op accepted from the issue stage.
module tb_sw_rs_entry_array;

  typedef struct {
    logic [7:0]  opc;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [5:0]  dst;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n, dp_stall, dp_kill, allocatable;
  logic [1:0]  req_num, alloc_ptr, issue_ptr;
  logic [15:0] dp_opc;
  logic [63:0] dp_src1, dp_src2;
  logic [1:0]  dp_rdy1, dp_rdy2;
  logic [11:0] dp_dst_tag;
  logic        cdb_valid, issue_valid, iss_ready;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [3:0]  busy_v, busy_next_v, ready_v;
  logic        fire, iss_valid;
  logic [7:0]  iss_opc;
  logic [31:0] iss_src1, iss_src2;
  logic [5:0]  iss_dst;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  sw_rs_entry_array #(
    .ENT_SEL (2), .ENT_NUM (4), .DATA_W (32), .TAG_W (6), .OPC_W (8)
  ) dut (
    .clk_i (clk), .reset_n_i (reset_n), .dp_stall_i (dp_stall), .dp_kill_i (dp_kill),
    .req_num_i (req_num), .alloc_ptr_i (alloc_ptr), .allocatable_i (allocatable),
    .dp_opc_i (dp_opc), .dp_src1_i (dp_src1), .dp_src2_i (dp_src2),
    .dp_rdy1_i (dp_rdy1), .dp_rdy2_i (dp_rdy2), .dp_dst_tag_i (dp_dst_tag),
    .cdb_valid_i (cdb_valid), .cdb_tag_i (cdb_tag), .cdb_data_i (cdb_data),
    .issue_ptr_i (issue_ptr), .issue_valid_i (issue_valid), .iss_ready_i (iss_ready),
    .busy_vector_o (busy_v), .busy_vector_next_o (busy_next_v), .ready_vector_o (ready_v),
    .issue_fire_o (fire), .iss_valid_o (iss_valid), .iss_opc_o (iss_opc),
    .iss_src1_o (iss_src1), .iss_src2_o (iss_src2), .iss_dst_tag_o (iss_dst)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dp_stall = 1'b0; dp_kill = 1'b0; allocatable = 1'b1; req_num = 2'd0;
    cdb_valid = 1'b0; issue_valid = 1'b0;
  endtask

  task automatic set_slot(input int s, input logic [7:0] opc, input logic [31:0] s1, input logic r1,
                          input logic [31:0] s2, input logic r2, input logic [5:0] dst);
    dp_opc[s*8 +: 8]       = opc;
    dp_src1[s*32 +: 32]    = s1;
    dp_src2[s*32 +: 32]    = s2;
    dp_rdy1[s]             = r1;
    dp_rdy2[s]             = r2;
    dp_dst_tag[s*6 +: 6]   = dst;
  endtask

  function automatic exp_t mk(input logic [7:0] opc, input logic [31:0] s1,
                              input logic [31:0] s2, input logic [5:0] dst);
    exp_t e;
    e.opc = opc; e.s1 = s1; e.s2 = s2; e.dst = dst;
    return e;
  endfunction

  // Monitor: every op accepted downstream must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && iss_valid && iss_ready) begin
        if (q.size() == 0) begin
          chk("iss_unexpected", {56'd0, iss_opc}, 64'hFFFF);
        end else begin
          e = q.pop_front();
          chk("iss_opc",  {56'd0, iss_opc},  {56'd0, e.opc});
          chk("iss_src1", {32'd0, iss_src1}, {32'd0, e.s1});
          chk("iss_src2", {32'd0, iss_src2}, {32'd0, e.s2});
          chk("iss_dst",  {58'd0, iss_dst},  {58'd0, e.dst});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic       bst [3] = '{1'b1, 1'b0, 1'b0};
    logic       bal [3] = '{1'b1, 1'b0, 1'b1};
    logic [1:0] brq [3] = '{2'd1, 2'd1, 2'd3};

    reset_n = 1'b0; idle(); iss_ready = 1'b1; alloc_ptr = 2'd0; issue_ptr = 2'd0;
    cdb_tag = '0; cdb_data = '0;
    dp_opc = '0; dp_src1 = '0; dp_src2 = '0; dp_rdy1 = '0; dp_rdy2 = '0; dp_dst_tag = '0;

    // Reset with dispatch active
    req_num = 2'd2;
    set_slot(0, 8'hA0, 32'h1, 1'b1, 32'h2, 1'b1, 6'd1);
    set_slot(1, 8'hA1, 32'h3, 1'b1, 32'h4, 1'b1, 6'd2);
    tick(); tick();
    @(negedge clk);
    chk("rst_busy", busy_v, 4'b0000);
    chk("rst_iss_valid", iss_valid, 1'b0);
    chk("rst_iss_opc", iss_opc, 8'h00);
    chk("rst_iss_src1", iss_src1, 32'h0);
    reset_n = 1'b1; idle();
    tick();

    // Dual dispatch wrapping 3 -> 0, then issue both
    alloc_ptr = 2'd3; req_num = 2'd2;
    set_slot(0, 8'h11, 32'h100, 1'b1, 32'h200, 1'b1, 6'd1);
    set_slot(1, 8'h22, 32'h300, 1'b1, 32'h400, 1'b1, 6'd2);
    @(negedge clk);
    chk("wrap_busy_next", busy_next_v, 4'b1001);
    chk("wrap_busy_pre", busy_v, 4'b0000);
    tick(); idle();
    issue_ptr = 2'd3; issue_valid = 1'b1; q.push_back(mk(8'h11, 32'h100, 32'h200, 6'd1));
    @(negedge clk);
    chk("wrap_busy", busy_v, 4'b1001);
    chk("wrap_ready", ready_v, 4'b1001);
    chk("wrap_fire3", fire, 1'b1);
    tick();
    issue_ptr = 2'd0; q.push_back(mk(8'h22, 32'h300, 32'h400, 6'd2));
    @(negedge clk);
    chk("wrap_fire0", fire, 1'b1);
    chk("wrap_busy_after3", busy_v, 4'b0001);
    chk("wrap_iss_valid", iss_valid, 1'b1);
    tick(); idle();
    @(negedge clk);
    chk("wrap_busy_empty", busy_v, 4'b0000);
    tick();
    @(negedge clk);
    chk("wrap_iss_drop", iss_valid, 1'b0);

    // Wakeup of src1 (tag 5), with a non-matching tag first
    alloc_ptr = 2'd0; req_num = 2'd1;
    set_slot(0, 8'h33, 32'h5, 1'b0, 32'h77, 1'b1, 6'd3);
    @(negedge clk);
    chk("wk_busy_next", busy_next_v, 4'b0001);
    tick(); idle();
    cdb_valid = 1'b1; cdb_tag = 6'd6; cdb_data = 32'hBAD;
    @(negedge clk);
    chk("wk_busy", busy_v, 4'b0001);
    chk("wk_not_ready", ready_v, 4'b0000);
    tick();
    cdb_tag = 6'd5; cdb_data = 32'hDEAD;
    @(negedge clk);
    chk("wk_wrong_tag", ready_v, 4'b0000);
    tick(); idle();
    issue_ptr = 2'd0; issue_valid = 1'b1; q.push_back(mk(8'h33, 32'hDEAD, 32'h77, 6'd3));
    @(negedge clk);
    chk("wk_ready", ready_v, 4'b0001);
    chk("wk_fire", fire, 1'b1);
    tick(); idle();
    @(negedge clk);
    chk("wk_busy_clr", busy_v, 4'b0000);
    tick();

    // Dispatch bypass of src2 (tag 7)
    alloc_ptr = 2'd1; req_num = 2'd1;
    set_slot(0, 8'h44, 32'h55, 1'b1, 32'h7, 1'b0, 6'd4);
    cdb_valid = 1'b1; cdb_tag = 6'd7; cdb_data = 32'h42;
    @(negedge clk);
    chk("byp_busy_next", busy_next_v, 4'b0010);
    tick(); idle();
    issue_ptr = 2'd1; issue_valid = 1'b1; q.push_back(mk(8'h44, 32'h55, 32'h42, 6'd4));
    @(negedge clk);
    chk("byp_ready", ready_v, 4'b0010);
    chk("byp_fire", fire, 1'b1);
    tick(); idle();
    @(negedge clk);
    chk("byp_busy_clr", busy_v, 4'b0000);
    tick();

    // Backpressure on the issue stage
    alloc_ptr = 2'd2; req_num = 2'd2;
    set_slot(0, 8'h55, 32'h1, 1'b1, 32'h2, 1'b1, 6'd5);
    set_slot(1, 8'h66, 32'h3, 1'b1, 32'h4, 1'b1, 6'd6);
    tick(); idle();
    iss_ready = 1'b0; issue_ptr = 2'd2; issue_valid = 1'b1;
    q.push_back(mk(8'h55, 32'h1, 32'h2, 6'd5));
    @(negedge clk);
    chk("bp_fire_first", fire, 1'b1);
    chk("bp_busy_both", busy_v, 4'b1100);
    tick();
    issue_ptr = 2'd3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_no_fire", fire, 1'b0);
      chk("bp_busy_kept", busy_v, 4'b1000);
      chk("bp_iss_hold", {iss_valid, iss_opc}, {1'b1, 8'h55});
      tick();
    end
    iss_ready = 1'b1; q.push_back(mk(8'h66, 32'h3, 32'h4, 6'd6));
    @(negedge clk);
    chk("bp_fire_release", fire, 1'b1);
    tick(); idle();
    @(negedge clk);
    chk("bp_busy_clr", busy_v, 4'b0000);
    tick();
    @(negedge clk);
    chk("bp_iss_drop", iss_valid, 1'b0);

    // Blocked writes: stall, no allocation grant, illegal req_num
    for (int i = 0; i < 3; i++) begin
      dp_stall = bst[i]; allocatable = bal[i]; req_num = brq[i]; alloc_ptr = 2'd1;
      set_slot(0, 8'h77, 32'h1, 1'b1, 32'h2, 1'b1, 6'd7);
      set_slot(1, 8'h78, 32'h1, 1'b1, 32'h2, 1'b1, 6'd8);
      @(negedge clk);
      chk("blk_busy_next", busy_next_v, 4'b0000);
      tick(); idle();
      @(negedge clk);
      chk("blk_busy", busy_v, 4'b0000);
      tick();
    end

    // Kill with busy entries, an occupied issue stage and a pending dispatch
    alloc_ptr = 2'd0; req_num = 2'd2;
    set_slot(0, 8'h71, 32'h1, 1'b1, 32'h2, 1'b1, 6'd1);
    set_slot(1, 8'h72, 32'h1, 1'b1, 32'h2, 1'b1, 6'd2);
    tick();
    alloc_ptr = 2'd2;
    set_slot(0, 8'h73, 32'h1, 1'b1, 32'h2, 1'b1, 6'd3);
    set_slot(1, 8'h74, 32'h9, 1'b0, 32'h2, 1'b1, 6'd4);
    @(negedge clk);
    chk("kill_setup_busy", busy_v, 4'b0011);
    tick(); idle();
    iss_ready = 1'b0; issue_ptr = 2'd0; issue_valid = 1'b1;
    @(negedge clk);
    chk("kill_pre_busy", busy_v, 4'b1111);
    chk("kill_pre_ready", ready_v, 4'b0111);
    tick();
    dp_kill = 1'b1; issue_ptr = 2'd1; req_num = 2'd1; alloc_ptr = 2'd0;
    cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'h99;
    @(negedge clk);
    chk("kill_fire_forced", fire, 1'b0);
    chk("kill_busy_3", busy_v, 4'b1110);
    chk("kill_busy_next", busy_next_v, 4'b0000);
    chk("kill_iss_valid_pre", iss_valid, 1'b1);
    tick(); idle();
    @(negedge clk);
    chk("kill_busy", busy_v, 4'b0000);
    chk("kill_ready", ready_v, 4'b0000);
    chk("kill_iss_valid", iss_valid, 1'b0);
    tick(); iss_ready = 1'b1;
    @(negedge clk);
    chk("kill_no_write", busy_v, 4'b0000);
    tick(); tick();

    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sw_rs_entry_array.md
Name: sw_rs_entry_array

Overview:
- Storage half of the in-order store-side reservation station.
- Upstream: dispatch. Sideways: the in-order alloc/issue pointer unit. Downstream: the store execution pipe.
- Writes dispatched ops into entries at the alloc pointer and captures operands from the result bus (wakeup).
- Exports busy and ready vectors to the pointer unit, and registers the entry at the issue pointer into a valid/ready issue output stage.

Parameters:
- ENT_SEL, 2, entry index width
- ENT_NUM, 4, entry count (power of two, equals 2^ENT_SEL)
- DATA_W, 32, operand width
- TAG_W, 6, rename tag width (TAG_W <= DATA_W)
- OPC_W, 8, opcode/control payload width

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous active-low reset
- dp_stall_i  in  1  dispatch stall
- dp_kill_i  in  1  flush all entries
- req_num_i  in  2  ops dispatched this cycle (0..2)
- alloc_ptr_i  in  ENT_SEL  first entry to write
- allocatable_i  in  1  pointer unit grants allocation
- dp_opc_i  in  2*OPC_W  slot0 in low half, slot1 in high half
- dp_src1_i, dp_src2_i  in  2*DATA_W each  operand value, or tag in low TAG_W bits when not ready
- dp_rdy1_i, dp_rdy2_i  in  2 each  per-slot operand-ready flags
- dp_dst_tag_i  in  2*TAG_W  destination tags
- cdb_valid_i  in  1  result bus valid
- cdb_tag_i  in  TAG_W  result tag
- cdb_data_i  in  DATA_W  result value
- issue_ptr_i  in  ENT_SEL  entry selected by pointer unit
- issue_valid_i  in  1  selected entry is ready
- iss_ready_i  in  1  downstream accepts
- busy_vector_o  out  ENT_NUM  registered busy bits
- busy_vector_next_o  out  ENT_NUM  busy after this cycle's writes and clears (combinational)
- ready_vector_o  out  ENT_NUM  busy and both operands ready (combinational from regs)
- issue_fire_o  out  1  entry consumed this cycle
- iss_valid_o  out  1  issue stage holds an op
- iss_opc_o  out  OPC_W
- iss_src1_o, iss_src2_o  out  DATA_W each
- iss_dst_tag_o  out  TAG_W

Behaviour:
- Reset (reset_n_i=0 at a clock edge):
  - all busy, rdy1 and rdy2 bits cleared; iss_valid_o=0; issue payload outputs=0.
  - Entry payloads not reset.
  - Reset overrides every other input in that cycle.
- Write enable:
  - we = ~dp_stall_i & ~dp_kill_i & allocatable_i.
  - req_num_i>=1: slot0 written to entry alloc_ptr_i.
  - req_num_i==2: slot1 also written to entry (alloc_ptr_i+1) mod ENT_NUM; wraps 3->0 at default size.
  - A written entry sets busy=1 next cycle.
- req_num_i==3 is illegal; no entry is written.
- Dispatch bypass: if cdb_valid_i and a dispatching operand is not ready with tag == cdb_tag_i, store cdb_data_i and set that rdy bit.
- Wakeup: each busy entry with rdy=0 and stored tag == cdb_tag_i captures cdb_data_i and sets rdy, taking effect next cycle.
- Issue:
  - issue_fire_o = issue_valid_i & busy[issue_ptr_i] & (~iss_valid_o | iss_ready_i).
  - On fire, the entry's payload is loaded into the issue regs, iss_valid_o=1, and busy is cleared next cycle.
  - Without a fire, iss_valid_o drops when iss_ready_i=1; otherwise the issue regs hold.
  - Latency: dispatch at cycle N makes the entry ready at N+1 at earliest; it can fire at N+1 and is visible on iss_valid_o at N+2.
- Simultaneous fire and write: these always target different entries, because allocation writes only non-busy entries and fire requires busy. Both take effect.
- Fire on an entry that is being woken the same cycle cannot occur, since fire requires the entry already ready.
- dp_kill_i: clears all busy bits and iss_valid_o next cycle, overriding writes and fire; issue_fire_o is forced to 0.
- dp_stall_i: blocks writes only; wakeup and issue continue.
- Full array: allocatable_i=0 blocks writes; this block never checks occupancy itself.

Optional Feature:
- SW_RS_DUAL_CDB_EN: when defined, adds ports cdb1_valid_i, cdb1_tag_i and cdb1_data_i.
  - Wakeup and bypass compare against both buses.
  - If both buses match, bus 0 wins.
- When undefined, there is a single bus and the extra ports are absent.

Decomposition:
- Package sw_rs_pkg holds:
  - default widths (ENT_SEL, DATA_W, TAG_W, OPC_W)
  - slot field offsets for the packed dp_* buses
  - the req_num encodings
- Sub-module sw_rs_entry: one entry's registers plus tag compare and capture logic; busy, ready and payload as outputs. Instantiated ENT_NUM times by a generate loop.

Test Plan:
- Reset: hold reset_n_i=0 two cycles with dispatch active -> busy_vector_o=0000, iss_valid_o=0.
- Dual dispatch with wrap: alloc_ptr_i=3, req_num_i=2, both operands ready -> next cycle busy=1001, ready=1001.
- Wakeup: entry 0 with src1 tag 5 not ready; cdb tag 5, data 0xDEAD -> next cycle ready[0]=1; issue_ptr=0 fires; iss_src1_o=0xDEAD one cycle later.
- Bypass: dispatch src2 tag 7 not ready, same cycle cdb tag 7 data 0x42 -> entry ready next cycle with src2=0x42.
- Backpressure: iss_valid_o=1, iss_ready_i=0, issue_valid_i=1 -> issue_fire_o=0, busy kept; raise iss_ready_i -> fire, busy bit clears next cycle.
- Kill during activity: 3 entries busy plus a pending dispatch, dp_kill_i=1 -> next cycle busy=0000, iss_valid_o=0, no writes.
